// File: rtl/apb3_traffic_generator.sv
// rtl/apb3_traffic_generator.sv - APB3 requester running a write-then-readback burst with error accounting
module apb3_traffic_generator #(
    parameter int unsigned             AddressWidth  = 32,
    parameter int unsigned             DataWidth     = 32,
    parameter int unsigned             TransferCount = 8,
    parameter logic [AddressWidth-1:0] BaseAddress   = '0,
    parameter int unsigned             AddressStride = 4,
    parameter int unsigned             IdleCycles    = 1,
    parameter int unsigned             TimeoutCycles = 1024,
    parameter logic [31:0]             SeedPattern   = 32'hA5A50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode_b2b,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [15:0]             error_count,
    output logic                    timeout,
    output logic [AddressWidth-1:0] paddr,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DataWidth-1:0]    pwdata,
    input  logic [DataWidth-1:0]    prdata,
    input  logic                    pready,
    input  logic                    pslverr
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int unsigned IW      = (TransferCount > 1) ? $clog2(TransferCount) : 1;
    localparam int unsigned GAP_LEN = (IdleCycles == 0) ? 1 : IdleCycles;
    localparam int unsigned TO_LEN  = (TimeoutCycles == 0) ? 1 : TimeoutCycles;
    localparam int unsigned GW      = $clog2(GAP_LEN + 1);
    localparam int unsigned WW      = $clog2(TO_LEN + 1);

    localparam logic [DataWidth-1:0]    SEED     = DataWidth'(SeedPattern);
    localparam logic [DataWidth-1:0]    DATA_ONE = DataWidth'(1);
    localparam logic [AddressWidth-1:0] STRIDE   = AddressWidth'(AddressStride);
    localparam logic [IW-1:0]           IDX_LAST = IW'(TransferCount - 1);
    localparam logic [IW-1:0]           IDX_ONE  = IW'(1);
    localparam logic [GW-1:0]           GAP_LOAD = GW'(GAP_LEN - 1);
    localparam logic [WW-1:0]           TO_LAST  = WW'(TO_LEN - 1);
    localparam logic [WW-1:0]           WAIT_ONE = WW'(1);

    logic [2:0]              r_state;
    logic [IW-1:0]           r_index;
    logic                    r_phase_read;
    logic                    r_mode_b2b;
    logic [AddressWidth-1:0] r_addr;
    logic [DataWidth-1:0]    r_data;
    logic [WW-1:0]           r_wait;
    logic [GW-1:0]           r_gap;
    logic [15:0]             r_error_count;
    logic                    r_timeout;
    logic                    r_done;
    logic                    r_busy;

    logic        w_in_apb;
    logic        w_complete;
    logic        w_mismatch;
    logic        w_slverr;
    logic        w_timeout_hit;
    logic        w_last;
    logic [1:0]  w_inc;
    logic [16:0] w_err_sum;
    logic [15:0] w_err_next;

    assign w_in_apb      = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign w_complete    = (r_state == S_ACCESS) && pready;
    assign w_mismatch    = w_complete && r_phase_read && (prdata != r_data);
    assign w_slverr      = w_complete && pslverr;
    assign w_timeout_hit = (r_state == S_ACCESS) && !pready && (r_wait == TO_LAST);
    assign w_last        = (r_index == IDX_LAST);
    // A read can carry both a slave error and a data mismatch, so up to 2 per cycle
    assign w_inc         = {1'b0, w_slverr} + {1'b0, w_mismatch} + {1'b0, w_timeout_hit};
    assign w_err_sum     = {1'b0, r_error_count} + {15'd0, w_inc};
    assign w_err_next    = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];

    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign error_count = r_error_count;
    assign pass        = r_done && (r_error_count == 16'd0) && !r_timeout;
    assign psel        = w_in_apb;
    assign penable     = (r_state == S_ACCESS);
    assign pwrite      = w_in_apb && !r_phase_read;
    assign paddr       = w_in_apb ? r_addr : '0;
    assign pwdata      = pwrite ? r_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_index       <= '0;
            r_phase_read  <= 1'b0;
            r_mode_b2b    <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_wait        <= '0;
            r_gap         <= '0;
            r_error_count <= 16'd0;
            r_timeout     <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state       <= S_SETUP;
                        r_index       <= '0;
                        r_phase_read  <= 1'b0;
                        r_mode_b2b    <= mode_b2b;
                        r_addr        <= BaseAddress;
                        r_data        <= SEED;
                        r_wait        <= '0;
                        r_error_count <= 16'd0;
                        r_timeout     <= 1'b0;
                        r_done        <= 1'b0;
                        r_busy        <= 1'b1;
                    end
                end
                S_SETUP: begin
                    r_state <= S_ACCESS;
                    r_wait  <= '0;
                end
                S_ACCESS: begin
                    r_error_count <= w_err_next;
                    if (pready) begin
                        if (w_last && r_phase_read) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= r_mode_b2b ? S_SETUP : S_GAP;
                            r_gap   <= GAP_LOAD;
                            if (w_last) begin
                                r_phase_read <= 1'b1;
                                r_index      <= '0;
                                r_addr       <= BaseAddress;
                                r_data       <= SEED;
                            end else begin
                                r_index <= r_index + IDX_ONE;
                                r_addr  <= r_addr + STRIDE;
                                r_data  <= r_data + DATA_ONE;
                            end
                        end
                    end else if (w_timeout_hit) begin
                        r_state   <= S_DONE;
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_wait <= r_wait + WAIT_ONE;
                    end
                end
                S_GAP: begin
                    if (r_gap == '0) begin
                        r_state <= S_SETUP;
                    end else begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb3_traffic_generator.sv
// tb/tb_apb3_traffic_generator.sv - directed bench for apb3_traffic_generator
module tb_apb3_traffic_generator;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, mode_b2b;
    logic        busy, done, pass, timeout, psel, penable, pwrite, pready, pslverr;
    logic [15:0] error_count;
    logic [31:0] paddr, pwdata, prdata;

    logic        start8, mode8;
    logic        busy8, done8, pass8, timeout8, psel8, penable8, pwrite8, pready8, pslverr8;
    logic [15:0] error_count8;
    logic [7:0]  paddr8;
    logic [31:0] pwdata8, prdata8;

    int tests = 0;
    int fails = 0;

    int wait_states, corrupt_idx, err_wr_idx, hang_wr_idx;
    int wcnt = 0;
    logic [31:0] mem  [0:31];
    logic [31:0] mem8 [0:255];
    logic        log_clr;
    int          n_wr, n_rd, psel_low, unstable, n_wr8;
    logic [31:0] wr_addr [0:31];
    logic [31:0] wr_data [0:31];
    logic [7:0]  wr8_addr [0:7];
    logic [31:0] s_addr, s_data;

    apb3_traffic_generator #(
        .IdleCycles(3),
        .TimeoutCycles(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode_b2b(mode_b2b),
        .busy(busy), .done(done), .pass(pass), .error_count(error_count), .timeout(timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    apb3_traffic_generator #(
        .AddressWidth(8),
        .TransferCount(4),
        .BaseAddress(8'hF8),
        .AddressStride(4)
    ) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode_b2b(mode8),
        .busy(busy8), .done(done8), .pass(pass8), .error_count(error_count8), .timeout(timeout8),
        .paddr(paddr8), .psel(psel8), .penable(penable8), .pwrite(pwrite8), .pwdata(pwdata8),
        .prdata(prdata8), .pready(pready8), .pslverr(pslverr8)
    );

    // Completer model: word-indexed memory, programmable waits, error injection
    always_comb begin
        pready  = psel && penable && (wcnt >= wait_states)
                  && !(pwrite && hang_wr_idx == int'(paddr[6:2]));
        pslverr = pwrite && (err_wr_idx == int'(paddr[6:2]));
        prdata  = mem[paddr[6:2]] ^ ((!pwrite && corrupt_idx == int'(paddr[6:2])) ? 32'h1 : 32'h0);
    end

    always_comb begin
        pready8  = psel8 && penable8;
        pslverr8 = 1'b0;
        prdata8  = mem8[paddr8];
    end

    always @(posedge clk) begin
        if (psel && penable && !pready) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (psel && penable && pready && pwrite) mem[paddr[6:2]] <= pwdata;
        if (psel8 && penable8 && pwrite8) mem8[paddr8] <= pwdata8;
    end

    always @(posedge clk) begin
        if (log_clr) begin
            n_wr <= 0; n_rd <= 0; psel_low <= 0; unstable <= 0; n_wr8 <= 0;
        end else begin
            if (psel && penable && pready) begin
                if (pwrite) begin
                    if (n_wr < 32) begin
                        wr_addr[n_wr] <= paddr;
                        wr_data[n_wr] <= pwdata;
                    end
                    n_wr <= n_wr + 1;
                end else begin
                    n_rd <= n_rd + 1;
                end
            end
            if (busy && !psel) psel_low <= psel_low + 1;
            if (psel && !penable) begin
                s_addr <= paddr;
                s_data <= pwdata;
            end
            if (psel && penable && (paddr != s_addr || pwdata != s_data)) unstable <= unstable + 1;
            if (psel8 && penable8 && pwrite8) begin
                if (n_wr8 < 8) wr8_addr[n_wr8] <= paddr8;
                n_wr8 <= n_wr8 + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_clr = 1'b1;
        @(posedge clk); #1;
        log_clr = 1'b0;
    endtask

    task automatic run(input logic b2b, input int bound, output int cycles);
        @(negedge clk);
        mode_b2b = b2b;
        start    = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        cycles = 0;
        while (!done && cycles < bound) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("run_done_within_bound", 64'(done), 64'd1);
    endtask

    initial begin
        int cyc;
        int k;
        rst = 1'b1; start = 1'b0; mode_b2b = 1'b0; start8 = 1'b0; mode8 = 1'b0;
        wait_states = 0; corrupt_idx = -1; err_wr_idx = -1; hang_wr_idx = -1;
        log_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_psel_penable", 64'({psel, penable, pwrite}), 64'd0);
        check("rst_paddr_pwdata", 64'({paddr, pwdata}), 64'd0);
        check("rst_errcnt_timeout", 64'({error_count, timeout}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        log_clr = 1'b0;

        // 1: back-to-back, zero-wait
        clear_log();
        run(1'b1, 200, cyc);
        check("t1_cycles", 64'(cyc), 64'd32);
        check("t1_pass", 64'(pass), 64'd1);
        check("t1_errcnt", 64'(error_count), 64'd0);
        check("t1_n_wr", 64'(n_wr), 64'd8);
        check("t1_n_rd", 64'(n_rd), 64'd8);
        check("t1_wr0_addr", 64'(wr_addr[0]), 64'h0);
        check("t1_wr0_data", 64'(wr_data[0]), 64'hA5A50000);
        check("t1_wr7_addr", 64'(wr_addr[7]), 64'h1C);
        check("t1_wr7_data", 64'(wr_data[7]), 64'hA5A50007);
        check("t1_psel_low", 64'(psel_low), 64'd0);
        check("t1_busy", 64'(busy), 64'd0);

        // 2: single mode, 3 idle cycles, 2 wait states per transfer
        wait_states = 2;
        clear_log();
        run(1'b0, 400, cyc);
        check("t2_cycles", 64'(cyc), 64'd109);
        check("t2_pass", 64'(pass), 64'd1);
        check("t2_unstable", 64'(unstable), 64'd0);
        check("t2_gap_cycles", 64'(psel_low), 64'd45);
        check("t2_n_wr", 64'(n_wr), 64'd8);

        // 3: slave error on write 2, corrupted read of word 5
        wait_states = 0; err_wr_idx = 2; corrupt_idx = 5;
        run(1'b1, 200, cyc);
        check("t3_cycles", 64'(cyc), 64'd32);
        check("t3_errcnt", 64'(error_count), 64'd2);
        check("t3_pass", 64'(pass), 64'd0);
        check("t3_done", 64'(done), 64'd1);

        // 4: third write never completes
        err_wr_idx = -1; corrupt_idx = -1; hang_wr_idx = 2;
        run(1'b1, 200, cyc);
        check("t4_cycles", 64'(cyc), 64'd21);
        check("t4_timeout", 64'(timeout), 64'd1);
        check("t4_errcnt", 64'(error_count), 64'd1);
        check("t4_psel", 64'(psel), 64'd0);
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_pass", 64'(pass), 64'd0);
        hang_wr_idx = -1;

        // 5: asynchronous reset during ACCESS of read 4
        wait_states = 2;
        @(negedge clk);
        mode_b2b = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!(psel && penable && !pwrite && paddr == 32'h10) && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        check("t5_reached_read4", 64'(psel && penable && !pwrite && paddr == 32'h10), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_async_psel", 64'(psel), 64'd0);
        check("t5_async_penable", 64'(penable), 64'd0);
        check("t5_async_busy", 64'(busy), 64'd0);
        check("t5_async_errcnt", 64'(error_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_states = 0;
        clear_log();
        run(1'b1, 200, cyc);
        check("t5_rerun_cycles", 64'(cyc), 64'd32);
        check("t5_rerun_pass", 64'(pass), 64'd1);
        check("t5_rerun_wr0_addr", 64'(wr_addr[0]), 64'h0);
        check("t5_rerun_n_wr", 64'(n_wr), 64'd8);

        // 6: 8-bit address wrap, start pulsed while busy
        clear_log();
        @(negedge clk);
        mode8 = 1'b1;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        cyc = 0;
        while (!done8 && cyc < 100) begin
            if (cyc == 3) start8 = 1'b1;
            @(posedge clk); #1;
            start8 = 1'b0;
            cyc++;
        end
        check("t6_cycles", 64'(cyc), 64'd16);
        check("t6_pass", 64'(pass8), 64'd1);
        check("t6_n_wr", 64'(n_wr8), 64'd4);
        check("t6_addr0", 64'(wr8_addr[0]), 64'hF8);
        check("t6_addr1", 64'(wr8_addr[1]), 64'hFC);
        check("t6_addr2", 64'(wr8_addr[2]), 64'h00);
        check("t6_addr3", 64'(wr8_addr[3]), 64'h04);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule
